parking_gate_controller: RTL and testbench

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

---
 rtl/parking_gate_controller.sv | 194 +++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - single-lane parking barrier controller with occupancy count
//
// Purpose:
//   Arbitrates one shared barrier between entry and exit requests, keeps a
//   saturating vehicle count and enforces a settle time after every pass.
//   All outputs are registered.
//
// Optional feature:
//   PARKING_GATE_TIMEOUT_EN - when defined, an open gate that sees no
//   matching pass for GATE_TIMEOUT cycles closes and pulses timeout.
//   When undefined, no timeout counter exists and timeout is tied 0.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         asynchronous active-high reset
//   entry_sensor  entry vehicle present (entry request level)
//   exit_sensor   exit vehicle present (exit request level)
//   entry_passed  one-cycle pulse, vehicle cleared the entry sensor
//   exit_passed   one-cycle pulse, vehicle cleared the exit sensor
//   gate_open     barrier open command
//   gate_dir      0 = entry granted, 1 = exit granted (valid while gate_open)
//   occupancy     current vehicle count
//   full          occupancy == CAPACITY
//   empty         occupancy == 0
//   entry_denied  one-cycle pulse, entry refused because the lot is full
//   timeout       one-cycle pulse, open gate closed without a pass

module parking_gate_controller #(
  parameter int CAPACITY     = 8'd20,
  parameter int OCC_W        = 8,
  parameter int CLOSE_DELAY  = 4,
  parameter int GATE_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic             entry_passed,
  input  logic             exit_passed,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             entry_denied,
  output logic             timeout
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);
  localparam int               CW  = $clog2(CLOSE_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSING    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    close_cnt, close_cnt_next;
  logic             last_served, last_served_next;  // 1 = exit was served last
  logic             denied_done, denied_done_next;  // denial already reported for this request
  logic             entry_ok, exit_ok, pick_exit, deny;
  logic             expire;

  logic             gate_open_d, gate_dir_d, full_d, empty_d, denied_d;
  logic [OCC_W-1:0] occ_next;

  assign entry_ok = entry_sensor && !full;
  assign exit_ok  = exit_sensor && !empty;
  // Exit wins when it is the only eligible side, or when both are eligible
  // and entry was the side served last.
  assign pick_exit = exit_ok && (!entry_ok || !last_served);
  // One denial per high period of entry_sensor, reported in IDLE only.
  assign deny = (state == IDLE) && entry_sensor && full && !denied_done;
  assign denied_done_next = entry_sensor && (denied_done || deny);

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam int TW = $clog2(GATE_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_d;

  assign expire = (to_cnt == TW'(GATE_TIMEOUT - 1));
  // A matching pass in the expiry cycle wins, so no pulse in that case.
  assign timeout_d = expire &&
                     (((state == ENTRY_OPEN) && !entry_passed) ||
                      ((state == EXIT_OPEN) && !exit_passed));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_d;
      if ((state == ENTRY_OPEN) || (state == EXIT_OPEN)) begin
        to_cnt <= to_cnt + TW'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  logic unused_gate_timeout;
  assign unused_gate_timeout = (GATE_TIMEOUT > 0);
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      close_cnt   <= '0;
      last_served <= 1'b0;
      denied_done <= 1'b0;
    end else begin
      state       <= state_next;
      close_cnt   <= close_cnt_next;
      last_served <= last_served_next;
      denied_done <= denied_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next       = state;
    close_cnt_next   = close_cnt;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        if (pick_exit) begin
          state_next       = EXIT_OPEN;
          last_served_next = 1'b1;
        end else if (entry_ok) begin
          state_next       = ENTRY_OPEN;
          last_served_next = 1'b0;
        end
      end
      ENTRY_OPEN: begin
        if (entry_passed || expire) begin
          state_next     = CLOSING;
          close_cnt_next = '0;
        end
      end
      EXIT_OPEN: begin
        if (exit_passed || expire) begin
          state_next     = CLOSING;
          close_cnt_next = '0;
        end
      end
      default: begin
        if (close_cnt == CW'(CLOSE_DELAY - 1)) begin
          state_next = IDLE;
        end else begin
          close_cnt_next = close_cnt + CW'(1);
        end
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    occ_next = occupancy;
    if ((state == ENTRY_OPEN) && entry_passed && (occupancy != CAP)) begin
      occ_next = occupancy + OCC_W'(1);
    end else if ((state == EXIT_OPEN) && exit_passed && (occupancy != '0)) begin
      occ_next = occupancy - OCC_W'(1);
    end
    gate_open_d = (state_next == ENTRY_OPEN) || (state_next == EXIT_OPEN);
    gate_dir_d  = (state_next == EXIT_OPEN);
    full_d      = (occ_next == CAP);
    empty_d     = (occ_next == '0);
    denied_d    = deny;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_open    <= 1'b0;
      gate_dir     <= 1'b0;
      occupancy    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_denied <= 1'b0;
    end else begin
      gate_open    <= gate_open_d;
      gate_dir     <= gate_dir_d;
      occupancy    <= occ_next;
      full         <= full_d;
      empty        <= empty_d;
      entry_denied <= denied_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - self-checking bench for parking_gate_controller
module tb_parking_gate_controller;

  localparam int CLOSE_DELAY  = 4;
  localparam int GATE_TIMEOUT = 32;
  localparam int CAP_A        = 20;
  localparam int CAP_B        = 2;
`ifdef PARKING_GATE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_IN    = 1;
  localparam int M_OUT   = 2;
  localparam int M_CLOSE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor, exit_sensor, entry_passed, exit_passed;
  logic       a_gate_open, a_gate_dir, a_full, a_empty, a_entry_denied, a_timeout;
  logic       b_gate_open, b_gate_dir, b_full, b_empty, b_entry_denied, b_timeout;
  logic [7:0] a_occupancy, b_occupancy;
  logic [13:0] a_vec, b_vec;

  always #5 clk = ~clk;

  parking_gate_controller #(.CAPACITY(CAP_A), .OCC_W(8), .CLOSE_DELAY(CLOSE_DELAY),
                            .GATE_TIMEOUT(GATE_TIMEOUT)) dut_a (
    .clk(clk), .reset(reset),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .entry_passed(entry_passed), .exit_passed(exit_passed),
    .gate_open(a_gate_open), .gate_dir(a_gate_dir), .occupancy(a_occupancy),
    .full(a_full), .empty(a_empty), .entry_denied(a_entry_denied), .timeout(a_timeout)
  );

  parking_gate_controller #(.CAPACITY(CAP_B), .OCC_W(8), .CLOSE_DELAY(CLOSE_DELAY),
                            .GATE_TIMEOUT(GATE_TIMEOUT)) dut_b (
    .clk(clk), .reset(reset),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .entry_passed(entry_passed), .exit_passed(exit_passed),
    .gate_open(b_gate_open), .gate_dir(b_gate_dir), .occupancy(b_occupancy),
    .full(b_full), .empty(b_empty), .entry_denied(b_entry_denied), .timeout(b_timeout)
  );

  assign a_vec = {a_gate_open, a_gate_dir, a_occupancy, a_full, a_empty, a_entry_denied, a_timeout};
  assign b_vec = {b_gate_open, b_gate_dir, b_occupancy, b_full, b_empty, b_entry_denied, b_timeout};

  // Reference model: which side holds the gate, how long the closing hold
  // still lasts, how long the gate has been open, and who was served last.
  typedef struct {
    int mode;
    int occ;
    int close_left;
    int open_cnt;
    bit last_exit;
    bit denied_seen;
    bit denied;
    bit to;
  } mdl_t;

  typedef struct {
    logic [3:0] in;    // {entry_sensor, exit_sensor, entry_passed, exit_passed}
    logic [1:0] gd;    // {gate_open, gate_dir}
    int         occ;
    logic [2:0] fed;   // {full, empty, entry_denied}
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl[13];
  int   total = 0;
  int   bad = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.occ = 0; m.close_left = 0; m.open_cnt = 0;
    m.last_exit = 1'b0; m.denied_seen = 1'b0; m.denied = 1'b0; m.to = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int cap, logic [3:0] in);
    mdl_t n;
    bit   es, xs, ep, xp, is_full, is_empty, pulse;
    n = m;
    {es, xs, ep, xp} = in;
    is_full  = (m.occ == cap);
    is_empty = (m.occ == 0);
    pulse = (m.mode == M_IDLE) && es && is_full && !m.denied_seen;
    n.denied = pulse;
    n.denied_seen = es && (m.denied_seen || pulse);
    n.to = 1'b0;
    if (m.mode == M_IDLE) begin
      if (xs && !is_empty && (!(es && !is_full) || !m.last_exit)) begin
        n.mode = M_OUT; n.last_exit = 1'b1; n.open_cnt = 0;
      end else if (es && !is_full) begin
        n.mode = M_IN; n.last_exit = 1'b0; n.open_cnt = 0;
      end
    end else if (m.mode == M_IN || m.mode == M_OUT) begin
      if ((m.mode == M_IN) ? ep : xp) begin
        if (m.mode == M_IN) n.occ = (m.occ < cap) ? m.occ + 1 : m.occ;
        else                n.occ = (m.occ > 0) ? m.occ - 1 : 0;
        n.mode = M_CLOSE; n.close_left = CLOSE_DELAY;
      end else if (TO_EN && (m.open_cnt + 1 >= GATE_TIMEOUT)) begin
        n.to = 1'b1; n.mode = M_CLOSE; n.close_left = CLOSE_DELAY;
      end else begin
        n.open_cnt = m.open_cnt + 1;
      end
    end else begin
      n.close_left = m.close_left - 1;
      if (n.close_left == 0) n.mode = M_IDLE;
    end
    return n;
  endfunction

  function automatic logic [13:0] mdl_out(mdl_t m, int cap);
    return {(m.mode == M_IN) || (m.mode == M_OUT), m.mode == M_OUT, 8'(m.occ),
            m.occ == cap, m.occ == 0, m.denied, m.to};
  endfunction

  function automatic vec_t mk(logic [3:0] in, logic [1:0] gd, int occ, logic [2:0] fed);
    vec_t v;
    v.in = in; v.gd = gd; v.occ = occ; v.fed = fed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, step the models at posedge, compare at negedge.
  task automatic cyc(input logic [3:0] in);
    {entry_sensor, exit_sensor, entry_passed, exit_passed} = in;
    @(posedge clk);
    ma = mdl_step(ma, CAP_A, in);
    mb = mdl_step(mb, CAP_B, in);
    @(negedge clk);
    check("model_a", 32'(a_vec), 32'(mdl_out(ma, CAP_A)));
    check("model_b", 32'(b_vec), 32'(mdl_out(mb, CAP_B)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {entry_sensor, exit_sensor, entry_passed, exit_passed} = 4'b0000;
    @(negedge clk);
    check("reset_state_a", 32'(a_vec), 32'(14'b00_00000000_0_1_0_0));
    check("reset_state_b", 32'(b_vec), 32'(14'b00_00000000_0_1_0_0));
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, cnt_den, cnt_to;
    logic seen_open;

    tbl[0]  = mk(4'b1000, 2'b10, 0, 3'b010);
    tbl[1]  = mk(4'b1000, 2'b10, 0, 3'b010);
    tbl[2]  = mk(4'b0010, 2'b00, 1, 3'b000);
    tbl[3]  = mk(4'b0000, 2'b00, 1, 3'b000);
    tbl[4]  = mk(4'b0000, 2'b00, 1, 3'b000);
    tbl[5]  = mk(4'b0000, 2'b00, 1, 3'b000);
    tbl[6]  = mk(4'b1000, 2'b00, 1, 3'b000);
    tbl[7]  = mk(4'b1000, 2'b10, 1, 3'b000);
    tbl[8]  = mk(4'b0010, 2'b00, 2, 3'b000);
    tbl[9]  = mk(4'b0000, 2'b00, 2, 3'b000);
    tbl[10] = mk(4'b0000, 2'b00, 2, 3'b000);
    tbl[11] = mk(4'b0000, 2'b00, 2, 3'b000);
    tbl[12] = mk(4'b0000, 2'b00, 2, 3'b000);

    // Basic entry, grant latency, closing hold
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].in);
      check($sformatf("table_row%0d", i),
            32'({a_gate_open, a_gate_dir, a_occupancy, a_full, a_empty, a_entry_denied}),
            32'({tbl[i].gd, 8'(tbl[i].occ), tbl[i].fed}));
    end

    // Both requests at occupancy 3: exit first, then entry
    cyc(4'b1000); cyc(4'b0010);
    repeat (5) cyc(4'b0000);
    check("occ_three", 32'(a_occupancy), 32'd3);
    cyc(4'b1100);
    check("both_exit_first", 32'({a_gate_open, a_gate_dir}), 32'(2'b11));
    cyc(4'b1101);
    check("exit_pass_occ", 32'(a_occupancy), 32'd2);
    repeat (5) cyc(4'b1100);
    check("then_entry", 32'({a_gate_open, a_gate_dir}), 32'(2'b10));
    cyc(4'b0010);
    check("entry_pass_occ", 32'(a_occupancy), 32'd3);
    repeat (5) cyc(4'b0000);

    // Full lot (capacity 2): single denial, exit still served
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(4'b1000); cyc(4'b0010);
      repeat (5) cyc(4'b0000);
    end
    cnt_den = 0;
    seen_open = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1000);
      cnt_den += int'(b_entry_denied);
      seen_open |= b_gate_open;
    end
    check("full_flag", 32'(b_full), 32'd1);
    check("full_no_grant", 32'(seen_open), 32'd0);
    check("denied_once", 32'(cnt_den), 32'd1);
    cyc(4'b1100);
    check("full_exit_granted", 32'({b_gate_open, b_gate_dir}), 32'(2'b11));
    cyc(4'b0001);
    repeat (5) cyc(4'b0000);

    // Empty lot ignores exit
    do_reset();
    seen_open = 1'b0;
    cyc(4'b0100); seen_open |= a_gate_open;
    cyc(4'b0101); seen_open |= a_gate_open;
    cyc(4'b0101); seen_open |= a_gate_open;
    check("empty_no_grant", 32'(seen_open), 32'd0);
    check("empty_occ", 32'(a_occupancy), 32'd0);

    // Gate held with no pass
    do_reset();
    cyc(4'b1000);
    check("hold_open", 32'(a_gate_open), 32'd1);
`ifdef PARKING_GATE_TIMEOUT_EN
    n = 0;
    cnt_to = 0;
    while (a_gate_open && n < 40) begin
      cyc(4'b0000);
      n++;
      cnt_to += int'(a_timeout);
    end
    check("timeout_cycles", 32'(n), 32'd32);
    repeat (3) begin
      cyc(4'b0000);
      cnt_to += int'(a_timeout);
    end
    check("timeout_pulses", 32'(cnt_to), 32'd1);
    check("timeout_occ", 32'(a_occupancy), 32'd0);
`else
    n = 0;
    cnt_to = 0;
    repeat (100) begin
      cyc(4'b0000);
      cnt_to += int'(a_timeout);
    end
    check("still_open_100", 32'(a_gate_open), 32'd1);
    check("no_timeout_pulse", 32'(cnt_to), 32'd0);
`endif

    // Wrong-direction pulse ignored, then async reset mid-grant
    do_reset();
    cyc(4'b1000); cyc(4'b0010);
    repeat (5) cyc(4'b0000);
    cyc(4'b1000);
    cyc(4'b0001);
    check("wrong_pulse_ignored", 32'({a_gate_open, a_gate_dir, a_occupancy}), 32'({2'b10, 8'd1}));
    reset = 1'b1;
    #1;
    check("async_reset", 32'({a_gate_open, a_occupancy, a_empty}), 32'({1'b0, 8'd0, 1'b1}));
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the models
    do_reset();
    repeat (4000) begin
      cyc({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
